// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: blanked 3-slot LED column scan with double-buffered frames
module matrix_scan_controller #(
    parameter int TICK_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int ROWS         = 7
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [3*ROWS-1:0] frame_data_i,
    input  logic              frame_valid_i,
    output logic              frame_ready_o,
    output logic [2:0]        ring_counter_o,
    output logic [ROWS-1:0]   rows_o,
    output logic              blank_o,
    output logic              frame_start_o
);
    localparam int MAXC = TICK_DIV > BLANK_CYCLES ? TICK_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3*ROWS-1:0] active_q, active_d, pending_q, pending_d;
    logic              pend_full_q, pend_full_d;
    logic [2:0]        ring_q, ring_d;
    logic [ROWS-1:0]   rows_q, rows_d;
    logic              blank_q, blank_d, fs_q, fs_d, ready_q, ready_d;
    logic              boundary, accept, swap;
    assign ring_counter_o = ring_q;
    assign rows_o         = rows_q;
    assign blank_o        = blank_q;
    assign frame_start_o  = fs_q;
    assign frame_ready_o  = ready_q;
    // state, buffers and registered outputs; reset forces the display dark at once
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            slot_q      <= 2'd2;
            cnt_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            ring_q      <= 3'b000;
            rows_q      <= '0;
            blank_q     <= 1'b1;
            fs_q        <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            ring_q      <= ring_d;
            rows_q      <= rows_d;
            blank_q     <= blank_d;
            fs_q        <= fs_d;
            ready_q     <= ready_d;
        end
    end
    // scan sequencing plus frame handshake; swaps only at the slot0->slot2 boundary
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
            slot_d  = 2'd2;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            state_d  = BLANK;
            slot_d   = 2'd2;
            cnt_d    = CW'(BLANK_CYCLES - 1);
            boundary = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == BLANK) begin
            state_d = SHOW;
            cnt_d   = CW'(TICK_DIV - 1);
        end else begin
            state_d  = BLANK;
            slot_d   = slot_q == 2'd0 ? 2'd2 : slot_q - 2'd1;
            cnt_d    = CW'(BLANK_CYCLES - 1);
            boundary = slot_q == 2'd0;
        end
        accept      = frame_valid_i && !pend_full_q;
        swap        = boundary && pend_full_q;
        active_d    = swap ? pending_q : active_q;
        pending_d   = accept ? frame_data_i : pending_q;
        pend_full_d = accept || (pend_full_q && !swap);
    end
    // outputs are decoded from the next state so they line up with the state register
    always_comb begin
        ring_d  = state_d == SHOW ? 3'b001 << slot_d : 3'b000;
        rows_d  = state_d == SHOW ? active_d[ROWS*slot_d +: ROWS] : '0;
        blank_d = state_d != SHOW;
        fs_d    = boundary;
        ready_d = !pend_full_d;
    end
endmodule

// File: doc/matrix_scan_controller.md
Name: matrix_scan_controller

Overview:
- Sequences the 3-bit one-hot ring counter that feeds the mirrored 3x5 column decoder of the LED matrix.
  - Ring bit 2 drives outer columns 0 and 4.
  - Ring bit 1 drives columns 1 and 3.
  - Ring bit 0 drives centre column 2.
- Drives the matching row pattern for each slot and inserts a blanking gap between slots to suppress ghosting.
- Double-buffers frames behind a valid/ready handshake so new images swap in only at frame boundaries.

Parameters:
- TICK_DIV, 1000: clocks each slot is shown (SHOW length); must be >= 1.
- BLANK_CYCLES, 16: clocks of blanking before each slot; must be >= 1.
- ROWS, 7: row lines per column.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  scan enable; low forces the display dark.
- frame_data  input  3*ROWS  frame image. Slice frame_data[ROWS*i +: ROWS] is the row pattern for ring_counter[i].
- frame_valid  input  1  frame_data is valid.
- frame_ready  output  1  pending buffer can accept a frame.
- ring_counter  output  3  one-hot slot select to the column decoder; 3'b000 when dark.
- rows  output  ROWS  row drive for the current slot; 0 when dark.
- blank  output  1  high whenever no slot is lit.
- frame_start  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-scan) produces:
  - state=IDLE, slot=2.
  - ring_counter=000, rows=0, blank=1, frame_start=0.
  - active buffer=0, pending buffer empty, frame_ready=1.
- States: IDLE, BLANK, SHOW. A single down-counter, wide enough for max(TICK_DIV, BLANK_CYCLES), times both BLANK and SHOW.
- IDLE:
  - Outputs are dark.
  - If enable=1, next state is BLANK with slot=2 and counter=BLANK_CYCLES-1.
  - This entry counts as a frame boundary: swap rule applies and frame_start pulses.
- BLANK:
  - ring_counter=000, rows=0, blank=1.
  - When counter=0, go to SHOW with counter=TICK_DIV-1.
  - Exactly BLANK_CYCLES clocks are spent in BLANK.
- SHOW:
  - ring_counter has only bit[slot] set; rows = active[ROWS*slot +: ROWS]; blank=0.
  - When counter=0, rotate slot 2->1->0->2 and go to BLANK.
- Frame boundary is the transition from slot 0 back to slot 2 (or the IDLE->BLANK entry). On that clock edge:
  - If pending is full: active <= pending, pending is marked empty.
  - frame_start=1 for the first BLANK cycle of slot 2.
- Scan order is 100 -> 010 -> 001 -> 100. Frame period is 3*(BLANK_CYCLES+TICK_DIV) clocks.
- Handshake:
  - frame_ready = !pending_full.
  - When frame_valid && frame_ready, frame_data is captured into pending and pending becomes full; frame_ready drops next cycle.
  - frame_data is ignored when frame_ready=0.
  - frame_valid may be held high; only one transfer occurs per ready window.
- Simultaneous accept and boundary with pending empty: the capture lands in pending and is shown from the next boundary, not the current one.
- Boundary with pending full: frame_ready returns to 1 on the cycle after the swap.
- Active buffer never changes mid-frame; tearing is forbidden.
- enable deassert in any state:
  - Next state IDLE, outputs dark next cycle, slot=2.
  - Active and pending contents are retained; handshake keeps operating.
- ring_counter is never multi-hot, and is never non-zero while blank=1.

Test Plan:
- Scan timing (TICK_DIV=4, BLANK_CYCLES=2): reset, load frame slices bit2=7'h41, bit1=7'h22, bit0=7'h1C, then enable=1.
  - Per slot: 2 blank cycles then 4 cycles of 100/41, repeated for 010/22 and 001/1C.
  - Period is 18 clocks; frame_start pulses every 18 clocks.
- Boundary swap: during slot 1 of frame N, offer frame B.
  - Accepted; frame_ready goes low.
  - Frame N finishes with the old image; B appears at the slot-2 SHOW of frame N+1.
  - frame_ready returns high the cycle after the boundary.
- Back-pressure: hold frame_valid high with a second frame C while pending is full.
  - No capture occurs; C is captured the cycle after the swap and displayed one frame later.
- Accept coincident with boundary: assert valid exactly on the boundary edge with pending empty.
  - Data is shown at the following boundary, not the current one.
- Mid-slot disable/enable: drop enable during SHOW of slot 1.
  - Next cycle ring_counter=000, rows=0, blank=1.
  - On re-enable, restarts at slot 2 with BLANK and a frame_start pulse.
- Async reset mid-SHOW with pending full:
  - Outputs go dark immediately without waiting for a clock.
  - After release: frame_ready=1, active=0, so rows stay 0 when re-enabled.
